// File: rtl/tt_vector_player_if.sv
// Signal bundle between a bench and the vector player: vector-memory write port,
// run control and the verdict outputs.
// Strobe semantics: wr_en, start and abort are single-cycle strobes sampled on the
// rising clock edge, with no valid/ready back-pressure. wr_en and start are dropped
// (not queued) while busy is high. abort is always accepted and wins over start.
// All outputs come from registers or from a decode of registered state.
interface tt_vector_player_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [IN_W-1:0]  wr_stim;
  logic [OUT_W-1:0] wr_exp;
  logic [OUT_W-1:0] wr_mask;
  logic             start;
  logic             abort;
  logic [AW:0]      num_vec;
  logic             loop_en;
  logic [OUT_W-1:0] dut_out;
  logic [IN_W-1:0]  stim;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] err_cnt;
  logic             first_err_vld;
  logic [AW-1:0]    first_err_idx;

  modport master (
    output wr_en, wr_addr, wr_stim, wr_exp, wr_mask, start, abort, num_vec, loop_en,
    output dut_out,
    input  stim, busy, done, err_cnt, first_err_vld, first_err_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_stim, wr_exp, wr_mask, start, abort, num_vec, loop_en,
    input  dut_out,
    output stim, busy, done, err_cnt, first_err_vld, first_err_idx
  );
endinterface

// File: rtl/tt_vector_player.sv
// Vector player: replays stored stimulus onto a DUT one entry per clock and checks
// the DUT output LAT cycles after each stimulus update against a masked expectation.
module tt_vector_player #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int DEPTH = 16,
  parameter int LAT   = 1,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  tt_vector_player_if.slave  bus_if,
  output logic [1:0]         dbg_state_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(LAT + 1);
  localparam logic [AW:0]    DEPTH_V = (AW + 1)'(DEPTH);
  localparam logic [AW:0]    ONE_N   = (AW + 1)'(1);
  localparam logic [DW-1:0]  LAT_V   = DW'(LAT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [IN_W-1:0]  stim_mem [DEPTH];
  logic [OUT_W-1:0] exp_mem  [DEPTH];
  logic [OUT_W-1:0] mask_mem [DEPTH];

  logic [AW-1:0]    idx_q;
  logic [AW:0]      num_q;
  logic [DW-1:0]    drain_q;
  logic [IN_W-1:0]  stim_q;

  // Stage holding the compare data of the vector currently on stim_q.
  logic             drv_vld_q;
  logic [OUT_W-1:0] drv_exp_q;
  logic [OUT_W-1:0] drv_mask_q;
  logic [AW-1:0]    drv_idx_q;

  // LAT-deep delay line; its last stage lines up with the DUT output sample.
  logic             pipe_vld_q  [LAT];
  logic [OUT_W-1:0] pipe_exp_q  [LAT];
  logic [OUT_W-1:0] pipe_mask_q [LAT];
  logic [AW-1:0]    pipe_idx_q  [LAT];

  logic [CNT_W-1:0] err_cnt_q;
  logic             ferr_vld_q;
  logic [AW-1:0]    ferr_idx_q;

  logic        busy;
  logic        start_ok;
  logic        drive_en;
  logic        last_vec;
  logic        drain_end;
  logic        cmp_vld;
  logic        mismatch;
  logic [AW:0] num_sel;

  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign start_ok  = bus_if.start && !bus_if.abort && !busy;
  assign drive_en  = (state_q == S_RUN) && !bus_if.abort;
  assign num_sel   = (bus_if.num_vec > DEPTH_V) ? DEPTH_V : bus_if.num_vec;
  assign last_vec  = ({1'b0, idx_q} == (num_q - ONE_N));
  // DRAIN lasts until the last driven vector has reached its compare edge.
  assign drain_end = (drain_q == LAT_V);
  assign cmp_vld   = pipe_vld_q[LAT-1] && !bus_if.abort;
  assign mismatch  = |((bus_if.dut_out ^ pipe_exp_q[LAT-1]) & pipe_mask_q[LAT-1]);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic; abort overrides everything.
  always_comb begin
    state_d = state_q;
    if (bus_if.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (bus_if.start) state_d = (num_sel == '0) ? S_DONE : S_RUN;
        S_RUN:          if (last_vec && !bus_if.loop_en) state_d = S_DRAIN;
        S_DRAIN:        if (drain_end) state_d = S_DONE;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  // Vector memory; writes are dropped while a run is in progress.
  always_ff @(posedge clk) begin
    if (bus_if.wr_en && !busy) begin
      stim_mem[bus_if.wr_addr] <= bus_if.wr_stim;
      exp_mem[bus_if.wr_addr]  <= bus_if.wr_exp;
      mask_mem[bus_if.wr_addr] <= bus_if.wr_mask;
    end
  end

  // Sequencer: entry index, pass length, drain timer and the stimulus register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      num_q   <= '0;
      drain_q <= '0;
      stim_q  <= '0;
    end else begin
      if (bus_if.abort) begin
        idx_q  <= '0;
        stim_q <= '0;
      end else if (start_ok) begin
        idx_q <= '0;
        num_q <= num_sel;
      end else if (drive_en) begin
        stim_q <= stim_mem[idx_q];
        idx_q  <= last_vec ? '0 : idx_q + AW'(1);
      end
      if (state_q != S_DRAIN)  drain_q <= '0;
      else if (!drain_end)     drain_q <= drain_q + DW'(1);
    end
  end

  // Compare pipeline: follows each driven vector, flushed by abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drv_vld_q  <= 1'b0;
      drv_exp_q  <= '0;
      drv_mask_q <= '0;
      drv_idx_q  <= '0;
      for (int i = 0; i < LAT; i++) begin
        pipe_vld_q[i]  <= 1'b0;
        pipe_exp_q[i]  <= '0;
        pipe_mask_q[i] <= '0;
        pipe_idx_q[i]  <= '0;
      end
    end else begin
      drv_vld_q      <= drive_en;
      drv_exp_q      <= exp_mem[idx_q];
      drv_mask_q     <= mask_mem[idx_q];
      drv_idx_q      <= idx_q;
      pipe_vld_q[0]  <= drv_vld_q && !bus_if.abort;
      pipe_exp_q[0]  <= drv_exp_q;
      pipe_mask_q[0] <= drv_mask_q;
      pipe_idx_q[0]  <= drv_idx_q;
      for (int i = 1; i < LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1] && !bus_if.abort;
        pipe_exp_q[i]  <= pipe_exp_q[i-1];
        pipe_mask_q[i] <= pipe_mask_q[i-1];
        pipe_idx_q[i]  <= pipe_idx_q[i-1];
      end
    end
  end

  // Verdict: saturating mismatch count and first failing entry, cleared by start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q  <= '0;
      ferr_vld_q <= 1'b0;
      ferr_idx_q <= '0;
    end else if (start_ok) begin
      err_cnt_q  <= '0;
      ferr_vld_q <= 1'b0;
      ferr_idx_q <= '0;
    end else if (cmp_vld && mismatch) begin
      if (err_cnt_q != CNT_MAX) err_cnt_q <= err_cnt_q + CNT_W'(1);
      if (!ferr_vld_q) begin
        ferr_vld_q <= 1'b1;
        ferr_idx_q <= pipe_idx_q[LAT-1];
      end
    end
  end

  assign bus_if.stim          = stim_q;
  assign bus_if.busy          = busy;
  assign bus_if.done          = (state_q == S_DONE);
  assign bus_if.err_cnt       = err_cnt_q;
  assign bus_if.first_err_vld = ferr_vld_q;
  assign bus_if.first_err_idx = ferr_idx_q;
  assign dbg_state_o          = state_q;
endmodule

// File: tb/tb_tt_vector_player.sv
// Bench for tt_vector_player with a registered-echo DUT (dut_out = previous stim[7:0]).
module tb_tt_vector_player;
  localparam int IN_W  = 16;
  localparam int OUT_W = 8;
  localparam int DEPTH = 16;
  localparam int LAT   = 1;
  localparam int CNT_W = 3;
  localparam int AW    = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       dbg_state;
  logic [OUT_W-1:0] echo_q;

  int checks = 0;
  int errors = 0;

  // Reference memory image and expected stimulus stream.
  logic [IN_W-1:0]  m_stim [DEPTH];
  logic [OUT_W-1:0] m_exp  [DEPTH];
  logic [OUT_W-1:0] m_mask [DEPTH];
  logic [IN_W-1:0]  exp_q [$];
  logic [IN_W-1:0]  stim_m = '0;

  tt_vector_player_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus_if ();

  tt_vector_player #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_if     (bus_if),
    .dbg_state_o(dbg_state)
  );

  // Clock and the echo DUT under test by the player.
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) echo_q <= '0;
    else        echo_q <= bus_if.stim[OUT_W-1:0];
  end
  assign bus_if.dut_out = echo_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit is_bad(input int j);
    return ((m_stim[j][OUT_W-1:0] ^ m_exp[j]) & m_mask[j]) != '0;
  endfunction

  task automatic write_entry(input int a, input logic [IN_W-1:0] s,
                             input logic [OUT_W-1:0] e, input logic [OUT_W-1:0] m);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = a[AW-1:0];
    bus_if.wr_stim = s;
    bus_if.wr_exp  = e;
    bus_if.wr_mask = m;
    tick();
    bus_if.wr_en = 1'b0;
    m_stim[a] = s;
    m_exp[a]  = e;
    m_mask[a] = m;
  endtask

  task automatic check_idle_outputs(input string tag, input logic [IN_W-1:0] s,
                                    input logic dn, input int ec, input logic fv, input int fi);
    check({tag, " stim"}, 32'(bus_if.stim), 32'(s));
    check({tag, " busy"}, 32'(bus_if.busy), 32'(0));
    check({tag, " done"}, 32'(bus_if.done), 32'(dn));
    check({tag, " err_cnt"}, 32'(bus_if.err_cnt), 32'(ec));
    check({tag, " first_vld"}, 32'(bus_if.first_err_vld), 32'(fv));
    check({tag, " first_idx"}, 32'(bus_if.first_err_idx), 32'(fi));
  endtask

  // Start a run of n vectors for the given number of passes and check every cycle.
  task automatic run_and_check(input int n, input int passes, input string tag);
    int ne, total, e_err, e_idx;
    logic e_vld;
    ne = (n > DEPTH) ? DEPTH : n;
    total = ne * passes;
    exp_q.delete();
    e_err = 0; e_vld = 1'b0; e_idx = 0;
    for (int p = 0; p < passes; p++) begin
      for (int j = 0; j < ne; j++) begin
        exp_q.push_back(m_stim[j]);
        if (is_bad(j)) begin
          if (e_err < CMAX) e_err++;
          if (!e_vld) begin e_vld = 1'b1; e_idx = j; end
        end
      end
    end
    bus_if.num_vec = n[AW:0];
    bus_if.loop_en = (passes > 1);
    bus_if.start   = 1'b1;
    tick();
    bus_if.start = 1'b0;
    if (ne == 0) begin
      check_idle_outputs({tag, " empty"}, stim_m, 1'b1, 0, 1'b0, 0);
      tick();
      check({tag, " empty busy later"}, 32'(bus_if.busy), 32'(0));
      return;
    end
    for (int c = 1; c <= total; c++) begin
      tick();
      check($sformatf("%s stim c%0d", tag, c), 32'(bus_if.stim), 32'(exp_q.pop_front()));
      check($sformatf("%s busy c%0d", tag, c), 32'(bus_if.busy), 32'(1));
      if (c == total - 1) bus_if.loop_en = 1'b0;
    end
    bus_if.loop_en = 1'b0;
    tick();
    check({tag, " drain busy"}, 32'(bus_if.busy), 32'(1));
    check({tag, " drain done"}, 32'(bus_if.done), 32'(0));
    tick();
    stim_m = m_stim[ne-1];
    check_idle_outputs({tag, " end"}, stim_m, 1'b1, e_err, e_vld, e_idx);
  endtask

  initial begin
    int e_err, e_idx;
    logic e_vld;
    bus_if.wr_en = 1'b0; bus_if.wr_addr = '0; bus_if.wr_stim = '0;
    bus_if.wr_exp = '0; bus_if.wr_mask = '0; bus_if.start = 1'b0;
    bus_if.abort = 1'b0; bus_if.num_vec = '0; bus_if.loop_en = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset", '0, 1'b0, 0, 1'b0, 0);
    rst_n = 1'b1;
    tick();

    // Four echo vectors, all matching.
    for (int i = 0; i < 4; i++) write_entry(i, IN_W'(i + 1), OUT_W'(i + 1), 8'hFF);
    run_and_check(4, 1, "basic");

    // Entry 2 wrong in bit 0: masked out, then compared.
    write_entry(2, 16'd3, 8'h02, 8'hFE);
    run_and_check(4, 1, "mask_fe");
    write_entry(2, 16'd3, 8'h02, 8'hFF);
    run_and_check(4, 1, "mask_ff");

    // All 16 wrong, two looped passes: counter saturates, no gap at wrap.
    for (int i = 0; i < DEPTH; i++) begin
      logic [IN_W-1:0] s;
      s = IN_W'($urandom);
      write_entry(i, s, ~s[OUT_W-1:0], 8'hFF);
    end
    run_and_check(16, 2, "saturate");

    // Empty run.
    run_and_check(0, 1, "num0");

    // Abort at index 5 with dropped writes during busy, start+abort together.
    for (int i = 0; i < DEPTH; i++) begin
      logic [IN_W-1:0] s;
      s = IN_W'($urandom);
      write_entry(i, s, s[OUT_W-1:0] ^ ((i == 1 || i == 6) ? 8'h10 : 8'h00), 8'hFF);
    end
    bus_if.num_vec = 5'd16; bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      bus_if.wr_en   = (c >= 2 && c <= 4);
      bus_if.wr_addr = '0;
      bus_if.wr_stim = 16'hDEAD;
      bus_if.wr_exp  = 8'h5A;
      bus_if.wr_mask = 8'hFF;
      tick();
      check($sformatf("abort stim c%0d", c), 32'(bus_if.stim), 32'(m_stim[c-1]));
    end
    bus_if.wr_en = 1'b0;
    bus_if.abort = 1'b1; bus_if.start = 1'b1;
    tick();
    bus_if.abort = 1'b0; bus_if.start = 1'b0;
    // Entries 0..2 reached their sample edge before the abort edge.
    e_err = 0; e_vld = 1'b0; e_idx = 0;
    for (int j = 0; j < 3; j++) begin
      if (is_bad(j)) begin
        e_err++;
        if (!e_vld) begin e_vld = 1'b1; e_idx = j; end
      end
    end
    stim_m = '0;
    check_idle_outputs("abort", '0, 1'b0, e_err, e_vld, e_idx);
    tick();
    check("abort stays idle", 32'(bus_if.busy), 32'(0));
    run_and_check(16, 1, "rerun");

    // Write and start in the same cycle.
    bus_if.wr_en = 1'b1; bus_if.wr_addr = '0; bus_if.wr_stim = 16'h01AA;
    bus_if.wr_exp = 8'hAA; bus_if.wr_mask = 8'hFF;
    bus_if.num_vec = 5'd1; bus_if.start = 1'b1;
    tick();
    bus_if.wr_en = 1'b0; bus_if.start = 1'b0;
    m_stim[0] = 16'h01AA; m_exp[0] = 8'hAA; m_mask[0] = 8'hFF;
    tick();
    check("wr_start stim", 32'(bus_if.stim), 32'h01AA);
    tick();
    tick();
    stim_m = 16'h01AA;
    check_idle_outputs("wr_start end", 16'h01AA, 1'b1, 0, 1'b0, 0);

    // Randomised runs.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        logic [IN_W-1:0] s;
        logic [OUT_W-1:0] flip;
        s = IN_W'($urandom);
        flip = ($urandom_range(0, 3) == 0) ? OUT_W'(1 << $urandom_range(0, OUT_W - 1)) : '0;
        write_entry(i, s, s[OUT_W-1:0] ^ flip,
                    ($urandom_range(0, 1) == 0) ? 8'hFF : OUT_W'($urandom));
      end
      run_and_check($urandom_range(0, 20), $urandom_range(1, 3), $sformatf("rand%0d", r));
    end

    // Asynchronous reset in the middle of a run, away from the clock edge.
    bus_if.num_vec = 5'd16; bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    repeat (4) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst", '0, 1'b0, 0, 1'b0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("after rst busy", 32'(bus_if.busy), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
